// File: rtl/qam16_slicer_if.sv
// Symbol-rate bus for the 16QAM slicer: one I/Q pair in per strobe,
// Gray decisions, slicer errors and the tracked reference level out.
interface qam16_slicer_if #(
    parameter int WIDTH = 18
);
    logic                    sym_en;
    logic signed [WIDTH-1:0] i_in;
    logic signed [WIDTH-1:0] q_in;
    logic [1:0]              i_sym;
    logic [1:0]              q_sym;
    logic [3:0]              nibble;
    logic                    out_valid;
    logic signed [WIDTH-1:0] err_i;
    logic signed [WIDTH-1:0] err_q;
    logic signed [WIDTH-1:0] ref_level;
    logic                    ref_update;

    modport master (
        output sym_en, i_in, q_in,
        input  i_sym, q_sym, nibble, out_valid, err_i, err_q, ref_level, ref_update
    );

    modport slave (
        input  sym_en, i_in, q_in,
        output i_sym, q_sym, nibble, out_valid, err_i, err_q, ref_level, ref_update
    );
endinterface

// File: rtl/qam16_slicer.sv
// 16QAM hard-decision slicer: two-stage pipeline with per-rail Gray decisions,
// saturated slicer error and a reference level tracked from mean |x| per window.
module qam16_slicer #(
    parameter int WIDTH    = 18,
    parameter int LOG2_WIN = 8,
    parameter int REF_INIT = 65536,
    parameter int REF_MIN  = 1024
) (
    input  logic          clk,
    input  logic          reset,
    qam16_slicer_if.slave bus
);
    localparam int EW    = WIDTH + 2;
    localparam int ACC_W = WIDTH + LOG2_WIN + 1;

    localparam logic signed [WIDTH-1:0] S_MAX      = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] S_MIN      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]        REF_INIT_V = WIDTH'(REF_INIT);
    localparam logic [WIDTH-1:0]        REF_MIN_V  = WIDTH'(REF_MIN);

    function automatic logic [WIDTH-1:0] abs_sat(input logic signed [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        if (x == S_MIN)
            r = S_MAX;
        else if (x[WIDTH-1])
            r = -x;
        else
            r = x;
        return r;
    endfunction

    logic signed [WIDTH-1:0] x_in [2];
    logic [WIDTH-1:0]        mag [2];
    logic [1:0]              sym_next [2];
    logic signed [WIDTH-1:0] err_next [2];

    logic                    s1_valid_reg;
    logic [WIDTH-1:0]        ref_level_reg;
    logic [ACC_W-1:0]        acc_reg;
    logic [LOG2_WIN-1:0]     win_cnt_reg;
    logic [1:0]              i_sym_reg;
    logic [1:0]              q_sym_reg;
    logic signed [WIDTH-1:0] err_i_reg;
    logic signed [WIDTH-1:0] err_q_reg;
    logic                    out_valid_reg;
    logic                    ref_update_reg;

    assign x_in[0] = bus.i_in;
    assign x_in[1] = bus.q_in;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rail
            logic signed [WIDTH-1:0] x_reg;
            logic [WIDTH-1:0]        mag_reg;
            logic signed [EW-1:0]    x_w;
            logic signed [EW-1:0]    r_w;
            logic signed [EW-1:0]    half_w;
            logic signed [EW-1:0]    outer_w;
            logic signed [EW-1:0]    ideal_w;
            logic signed [EW-1:0]    diff_w;
            logic [1:0]              sym_c;
            logic signed [WIDTH-1:0] err_c;

            always_ff @(posedge clk) begin
                if (reset) begin
                    x_reg   <= '0;
                    mag_reg <= '0;
                end else if (bus.sym_en) begin
                    x_reg   <= x_in[gi];
                    mag_reg <= abs_sat(x_in[gi]);
                end
            end

            // Thresholds at 0 and +/-R; ideal levels at +/-R/2 and +/-1.5R.
            always_comb begin
                x_w     = EW'(x_reg);
                r_w     = EW'(ref_level_reg);
                half_w  = r_w >>> 1;
                outer_w = r_w + half_w;
                sym_c   = 2'b00;
                ideal_w = -outer_w;
                if (x_w >= r_w) begin
                    sym_c   = 2'b10;
                    ideal_w = outer_w;
                end else if (!x_w[EW-1]) begin
                    sym_c   = 2'b11;
                    ideal_w = half_w;
                end else if (x_w >= -r_w) begin
                    sym_c   = 2'b01;
                    ideal_w = -half_w;
                end
                diff_w = x_w - ideal_w;
                if (diff_w > EW'(S_MAX))
                    err_c = S_MAX;
                else if (diff_w < EW'(S_MIN))
                    err_c = S_MIN;
                else
                    err_c = diff_w[WIDTH-1:0];
            end

            assign mag[gi]      = mag_reg;
            assign sym_next[gi] = sym_c;
            assign err_next[gi] = err_c;
        end
    endgenerate

    logic [ACC_W-1:0] acc_sum;
    logic [WIDTH-1:0] ref_calc;
    logic [WIDTH-1:0] ref_next;
    logic             win_last;

    // Mean of |i|+|q| over 2^LOG2_WIN symbols, i.e. sum / 2^(LOG2_WIN+1).
    always_comb begin
        acc_sum  = acc_reg + ACC_W'(mag[0]) + ACC_W'(mag[1]);
        ref_calc = WIDTH'(acc_sum >> (LOG2_WIN + 1));
        ref_next = (ref_calc < REF_MIN_V) ? REF_MIN_V : ref_calc;
        win_last = &win_cnt_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= bus.sym_en;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_level_reg  <= REF_INIT_V;
            acc_reg        <= '0;
            win_cnt_reg    <= '0;
            i_sym_reg      <= '0;
            q_sym_reg      <= '0;
            err_i_reg      <= '0;
            err_q_reg      <= '0;
            out_valid_reg  <= 1'b0;
            ref_update_reg <= 1'b0;
        end else begin
            out_valid_reg  <= s1_valid_reg;
            ref_update_reg <= s1_valid_reg && win_last;
            if (s1_valid_reg) begin
                i_sym_reg   <= sym_next[0];
                q_sym_reg   <= sym_next[1];
                err_i_reg   <= err_next[0];
                err_q_reg   <= err_next[1];
                win_cnt_reg <= win_cnt_reg + 1'b1;
                // The closing symbol was sliced with the old R; new R takes over next.
                if (win_last) begin
                    acc_reg       <= '0;
                    ref_level_reg <= ref_next;
                end else begin
                    acc_reg <= acc_sum;
                end
            end
        end
    end

    assign bus.i_sym      = i_sym_reg;
    assign bus.q_sym      = q_sym_reg;
    assign bus.nibble     = {i_sym_reg, q_sym_reg};
    assign bus.err_i      = err_i_reg;
    assign bus.err_q      = err_q_reg;
    assign bus.ref_level  = ref_level_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.ref_update = ref_update_reg;
endmodule

// File: doc/qam16_slicer.md
Name: qam16_slicer

Overview:
- Receiver-side inverse of the 16QAM symbol mapper, placed after the matched filter/downsampler.
- Takes one I/Q sample pair per symbol strobe and makes hard 2-bit Gray decisions per rail.
- Outputs the 4-bit symbol plus the slicer error per rail.
- Tracks the reference level (R) itself from the mean sample magnitude.

Parameters:
- WIDTH, 18, sample/level/error width, signed two's complement
- LOG2_WIN, 8, reference estimation window = 2^LOG2_WIN symbols
- REF_INIT, 65536, reference level after reset and before the first window completes
- REF_MIN, 1024, lower clamp for the estimated reference level

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sym_en  in  1  symbol strobe; i_in/q_in valid this cycle
- i_in  in  WIDTH  signed in-phase sample
- q_in  in  WIDTH  signed quadrature sample
- i_sym  out  2  in-phase decision
- q_sym  out  2  quadrature decision
- nibble  out  4  {i_sym, q_sym}
- out_valid  out  1  one-cycle pulse; decisions/errors valid
- err_i  out  WIDTH  signed i_in minus ideal I level, saturated
- err_q  out  WIDTH  signed q_in minus ideal Q level, saturated
- ref_level  out  WIDTH  current reference level R (positive)
- ref_update  out  1  one-cycle pulse when ref_level changes from a window

Behaviour:
- Reset (synchronous, active-high):
  - ref_level=REF_INIT.
  - i_sym, q_sym, nibble, err_i, err_q = 0; out_valid=0; ref_update=0.
  - Window counter and accumulator cleared; pipeline valids cleared.
  - Reset mid-window discards all partial accumulation.
- Pipeline, 2 stages; latency 2: sym_en at cycle n -> out_valid at n+2. Back-to-back strobes are allowed, full throughput. No backpressure. Cycles without sym_en are ignored.
- Stage 1: registers i_in, q_in and their magnitudes. |x| for x=-2^(WIDTH-1) saturates to 2^(WIDTH-1)-1.
- Stage 2 decision per rail, using the ref_level register value in that cycle (R):
  - x >= R -> 10
  - 0 <= x < R -> 11
  - -R <= x < 0 -> 01
  - x < -R -> 00
  - Ties: x=R -> 10, x=0 -> 11, x=-R -> 01.
- Ideal levels match the transmit mapper: 00 = -(R + (R>>>1)); 01 = -(R>>>1); 11 = +(R>>>1); 10 = +(R + (R>>>1)).
- Error: x minus ideal, computed at WIDTH+2 bits, saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Reference estimation: for uniform 16QAM, mean |x| = R.
  - Accumulator, unsigned, WIDTH+LOG2_WIN+1 bits, adds |i|+|q| of each accepted symbol in stage 2.
  - Window counter counts accepted symbols 0..2^LOG2_WIN-1 and wraps.
  - On the last symbol of a window: ref_level <= (acc + |i| + |q|) >> (LOG2_WIN+1), clamped up to REF_MIN if smaller; acc <= 0; ref_update pulses in the same cycle as that symbol's out_valid.
  - That symbol's decision and error use the old R. The new R applies from the next symbol onward.
- Outputs hold their last values between out_valid pulses.

Test Plan:
1. Reset, R=65536, sym_en with i=98304, q=-32768 -> 2 cycles later out_valid=1, i_sym=10, q_sym=01, nibble=1001, err_i=0, err_q=0.
2. Threshold sweep on I, R=65536, Q held at 32768 -> expected I decisions:
   - i=65536 -> 10
   - i=65535 -> 11
   - i=0 -> 11
   - i=-1 -> 01
   - i=-65536 -> 01
   - i=-65537 -> 00
   - q_sym=11 throughout.
3. Errors and extremes, R=65536:
   - i=100000 -> err_i=1696
   - i=-131072 -> i_sym=00, err_i=-32768
   - i=131071 -> err_i=32767
   - Back-to-back strobes give one out_valid per strobe at +2.
4. Adaptation, LOG2_WIN=2, symbols (60000,20000), (-20000,-60000), (20000,60000), (-60000,-20000):
   - ref_update pulses with the 4th out_valid; ref_level=40000.
   - Next symbol (50000, -30000) -> i_sym=10, err_i=-10000; q_sym=01, err_q=-10000.
5. Silence, LOG2_WIN=2, four symbols of (0,0) -> ref_level=REF_MIN=1024 after the window; all decisions 11.
6. Reset asserted after 2 of 4 window symbols, then 4 full-scale symbols at R=40000 -> ref_level=REF_INIT until the new window completes, then 40000. out_valid stays low for the symbols flushed by reset.
